// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg. The master drives the mode, serial and
// parallel inputs; the slave (the shifter) returns its register and status.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       sel;
    logic             sin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             sout;
    logic             sout_vld;
    logic             busy;
    logic             done;

    modport master (
        output en, sel, sin, pin,
        input  pout, sout, sout_vld, busy, done
    );

    modport slave (
        input  en, sel, sin, pin,
        output pout, sout, sout_vld, busy, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, logical/arithmetic shifts, rotates,
// parallel load, and an autonomous LSB-first burst serialiser with busy/done.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_,
    universal_shift_reg_if.slave bus
);
    localparam logic [2:0] SEL_HOLD = 3'b000;
    localparam logic [2:0] SEL_SHR  = 3'b001;
    localparam logic [2:0] SEL_SHL  = 3'b010;
    localparam logic [2:0] SEL_LOAD = 3'b011;
    localparam logic [2:0] SEL_ROR  = 3'b100;
    localparam logic [2:0] SEL_ROL  = 3'b101;
    localparam logic [2:0] SEL_ASR  = 3'b110;
    localparam logic [2:0] SEL_BRST = 3'b111;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    r_cnt;
    logic             r_sout;
    logic             r_sout_vld;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            r_state    <= ST_IDLE;
            r_reg      <= '0;
            r_cnt      <= '0;
            r_sout     <= 1'b0;
            r_sout_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (!bus.en) begin
            // Frozen: only the one-cycle pulses are allowed to fall.
            r_sout_vld <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sout_vld <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    case (bus.sel)
                        SEL_HOLD: ;
                        SEL_SHR: begin
                            r_reg      <= {bus.sin, r_reg[WIDTH-1:1]};
                            r_sout     <= r_reg[0];
                            r_sout_vld <= 1'b1;
                        end
                        SEL_SHL: begin
                            r_reg      <= {r_reg[WIDTH-2:0], bus.sin};
                            r_sout     <= r_reg[WIDTH-1];
                            r_sout_vld <= 1'b1;
                        end
                        SEL_LOAD: r_reg <= bus.pin;
                        SEL_ROR: begin
                            r_reg      <= {r_reg[0], r_reg[WIDTH-1:1]};
                            r_sout     <= r_reg[0];
                            r_sout_vld <= 1'b1;
                        end
                        SEL_ROL: begin
                            r_reg      <= {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
                            r_sout     <= r_reg[WIDTH-1];
                            r_sout_vld <= 1'b1;
                        end
                        SEL_ASR: begin
                            r_reg      <= {r_reg[WIDTH-1], r_reg[WIDTH-1:1]};
                            r_sout     <= r_reg[0];
                            r_sout_vld <= 1'b1;
                        end
                        SEL_BRST: begin
                            r_reg   <= bus.pin;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_BURST;
                        end
                        default: ;
                    endcase
                end
                ST_BURST: begin
                    // sel is ignored here, so a repeated start cannot restart the burst.
                    r_reg      <= {bus.sin, r_reg[WIDTH-1:1]};
                    r_sout     <= r_reg[0];
                    r_sout_vld <= 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pout     = r_reg;
    assign bus.sout     = r_sout;
    assign bus.sout_vld = r_sout_vld;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule
